uart_rx_line_conditioner: RTL



---
 rtl/uart_pkg.sv | 28 ++
 rtl/uart_baud_gen.sv | 51 +++++
 rtl/uart_rx_line_conditioner.sv | 121 ++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: shared constants and helpers for the UART receive/transmit path.
//   OVERSAMPLE     - sample ticks per bit time
//   BREAK_TICKS    - consecutive low ticks that qualify as a line break (10 bit times)
//   IDLE_TICKS     - consecutive high ticks that qualify as an idle line (1 bit time)
//   RUN_CNT_WIDTH  - width of the saturating run-length counters
package uart_pkg;

    localparam int OVERSAMPLE    = 16;
    localparam int BREAK_TICKS   = 10 * OVERSAMPLE;
    localparam int IDLE_TICKS    = OVERSAMPLE;
    localparam int RUN_CNT_WIDTH = 8;

    // Thresholds sized to the run-length counters so comparisons stay width-clean.
    localparam logic [RUN_CNT_WIDTH-1:0] BREAK_CNT = RUN_CNT_WIDTH'(BREAK_TICKS);
    localparam logic [RUN_CNT_WIDTH-1:0] IDLE_CNT  = RUN_CNT_WIDTH'(IDLE_TICKS);
    localparam logic [RUN_CNT_WIDTH-1:0] CNT_ONE   = RUN_CNT_WIDTH'(1);

    // 2-of-3 vote used by the glitch filter.
    function automatic logic majority3(input logic [2:0] s);
        return (s[0] & s[1]) | (s[0] & s[2]) | (s[1] & s[2]);
    endfunction

    // Saturating increment for the run-length counters.
    function automatic logic [RUN_CNT_WIDTH-1:0] sat_inc(input logic [RUN_CNT_WIDTH-1:0] v);
        return (v == '1) ? v : v + CNT_ONE;
    endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// uart_baud_gen: programmable divider producing a one-cycle sample tick.
// Ports:
//   clk       - system clock
//   reset     - asynchronous, active-high
//   enable    - low holds the counter at 0 and suppresses ticks
//   baud_div  - clk cycles per tick; 0 and 1 both give a tick every cycle
//   tick      - registered one-cycle strobe, period max(baud_div,1)
// The tick is a pure strobe: it has no ready/acknowledge, consumers must act
// on the cycle it is high.
module uart_baud_gen #(
    parameter int DIV_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 enable,
    input  logic [DIV_WIDTH-1:0] baud_div,
    output logic                 tick
);

    localparam logic [DIV_WIDTH-1:0] DIV_ONE = DIV_WIDTH'(1);

    logic [DIV_WIDTH-1:0] div_cnt;
    logic [DIV_WIDTH-1:0] limit;

    // Terminal count; baud_div=0 is treated like 1 instead of wrapping to all-ones.
    always_comb begin
        limit = '0;
        if (baud_div != '0) begin
            limit = baud_div - DIV_ONE;
        end
    end

    // ">=" rather than "==" so a divisor lowered below the current count
    // fires on the next cycle instead of wrapping through 2^DIV_WIDTH.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_cnt <= '0;
            tick    <= 1'b0;
        end else if (!enable) begin
            div_cnt <= '0;
            tick    <= 1'b0;
        end else if (div_cnt >= limit) begin
            div_cnt <= '0;
            tick    <= 1'b1;
        end else begin
            div_cnt <= div_cnt + DIV_ONE;
            tick    <= 1'b0;
        end
    end

endmodule

// File: rtl/uart_rx_line_conditioner.sv
// uart_rx_line_conditioner: front end between the rx pad and the UART receiver.
// Synchronises rx_pin, generates the 16x sample tick, majority-filters the
// line over three ticks and reports start edges, line break and line idle.
// Ports:
//   clk, reset       - system clock; asynchronous active-high reset
//   enable           - low holds the block idle (line reads 1, no ticks, flags 0)
//   baud_div         - clk cycles per sample tick
//   rx_pin           - raw asynchronous serial line, idle high
//   serial_data_out  - filtered line value
//   sample_tick      - one-cycle oversample strobe
//   start_edge       - one-cycle pulse when serial_data_out goes 1->0
//   break_detect     - level, line low for BREAK_TICKS ticks
//   line_idle        - level, line high for IDLE_TICKS ticks
// SYNC_STAGES must be 2..4.
module uart_rx_line_conditioner
    import uart_pkg::*;
#(
    parameter int DIV_WIDTH   = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 enable,
    input  logic [DIV_WIDTH-1:0] baud_div,
    input  logic                 rx_pin,
    output logic                 serial_data_out,
    output logic                 sample_tick,
    output logic                 start_edge,
    output logic                 break_detect,
    output logic                 line_idle
);

    logic [SYNC_STAGES-1:0]   sync_ff;
    logic                     rx_sync;
    logic [2:0]               samples;
    logic                     filt_next;
    logic [RUN_CNT_WIDTH-1:0] low_cnt;
    logic [RUN_CNT_WIDTH-1:0] high_cnt;
    logic [RUN_CNT_WIDTH-1:0] low_inc;
    logic [RUN_CNT_WIDTH-1:0] high_inc;

    uart_baud_gen #(
        .DIV_WIDTH (DIV_WIDTH)
    ) u_baud_gen (
        .clk      (clk),
        .reset    (reset),
        .enable   (enable),
        .baud_div (baud_div),
        .tick     (sample_tick)
    );

    // The synchroniser keeps running while disabled so the line state is
    // already settled when the block is re-enabled.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_ff <= '1;
        end else begin
            sync_ff <= {sync_ff[SYNC_STAGES-2:0], rx_pin};
        end
    end

    assign rx_sync   = sync_ff[SYNC_STAGES-1];
    assign filt_next = majority3(samples);
    assign low_inc   = sat_inc(low_cnt);
    assign high_inc  = sat_inc(high_cnt);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            samples         <= '1;
            serial_data_out <= 1'b1;
            start_edge      <= 1'b0;
            low_cnt         <= '0;
            high_cnt        <= '0;
            break_detect    <= 1'b0;
            line_idle       <= 1'b0;
        end else if (!enable) begin
            samples         <= '1;
            serial_data_out <= 1'b1;
            start_edge      <= 1'b0;
            low_cnt         <= '0;
            high_cnt        <= '0;
            break_detect    <= 1'b0;
            line_idle       <= 1'b0;
        end else begin
            if (sample_tick) begin
                samples <= {samples[1:0], rx_sync};
            end

            // Filtered value is re-registered every cycle, so it follows the
            // sample register one cycle after a capture changes the vote.
            serial_data_out <= filt_next;
            start_edge      <= serial_data_out & ~filt_next;

            // Run lengths are judged on the filtered value as seen on the tick.
            if (sample_tick) begin
                if (serial_data_out) begin
                    low_cnt      <= '0;
                    high_cnt     <= high_inc;
                    break_detect <= 1'b0;
                    if (high_inc >= IDLE_CNT) begin
                        line_idle <= 1'b1;
                    end
                end else begin
                    high_cnt  <= '0;
                    low_cnt   <= low_inc;
                    line_idle <= 1'b0;
                    if (low_inc >= BREAK_CNT) begin
                        break_detect <= 1'b1;
                    end
                end
            end

            // Idle drops together with start_edge, not on the later tick;
            // placed last so it wins over a set on the same edge.
            if (!filt_next) begin
                line_idle <= 1'b0;
            end
        end
    end

endmodule
